motion_code_decoder: RTL
========================

MOTION_CODE_DECODER -- requirements
Module: motion_code_decoder

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, PWM counter width.
REQ-002 The block SHALL have parameter DUTY, default 192, PWM on-count per period; legal range 0..2^PWM_BITS; width PWM_BITS+1.
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 16, motor-off interval on direction reversal; legal range 1..255.
REQ-004 Port CLK, input, 1 bit: the single clock; all logic rising-edge.
REQ-005 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port CODE, input, 3 bits: motion code, held level, may change on any cycle.
REQ-007 Port LEFT_EN, output, 1 bit: left motor PWM enable.
REQ-008 Port LEFT_DIR, output, 1 bit: left motor direction; 1 = forward, 0 = reverse.
REQ-009 Port RIGHT_EN, output, 1 bit: right motor PWM enable.
REQ-010 Port RIGHT_DIR, output, 1 bit: right motor direction; 1 = forward, 0 = reverse.
REQ-011 Port ACTIVE_CODE, output, 3 bits: the registered code currently being acted on.
REQ-012 Port BUSY, output, 1 bit: high while either motor is in DEAD.

Function
REQ-013 CODE SHALL be registered into ACTIVE_CODE every cycle; 3'b111 SHALL be registered as STOP (000).
REQ-014 Per-motor requests from ACTIVE_CODE, given as left/right, SHALL be: 000 off/off; 001 fwd/fwd; 010 rev/rev; 011 (RIGHT1X) fwd/off; 100 (RIGHT2X) fwd/rev; 101 (LEFT1X) off/fwd; 110 (LEFT2X) rev/fwd.
REQ-015 Each motor SHALL run an independent FSM with states IDLE, RUN and DEAD, plus a direction register and an 8-bit dead counter.
REQ-016 IDLE with request off SHALL stay in IDLE.
REQ-017 IDLE with request fwd or rev SHALL load DIR from the request and go to RUN in the same cycle.
REQ-018 RUN with request of the same direction SHALL stay in RUN.
REQ-019 RUN with request off SHALL go to IDLE, with DIR held.
REQ-020 RUN with request of the opposite direction SHALL go to DEAD, load the counter with DEAD_CYCLES-1 and hold DIR.
REQ-021 In DEAD, the counter SHALL decrement each cycle; requests are ignored until the counter reaches 0.
REQ-022 DEAD with counter 0 SHALL act on the current request: off -> IDLE; fwd/rev -> RUN with DIR loaded.
REQ-023 The motor SHALL therefore be disabled for exactly DEAD_CYCLES cycles on a reversal.
REQ-024 DIR SHALL never change while the state is RUN.
REQ-025 PWM_CNT SHALL be a free-running PWM_BITS counter shared by both motors, wrapping from 2^PWM_BITS-1 to 0.
REQ-026 pwm_on SHALL be (PWM_CNT < DUTY): DUTY=0 gives never on; DUTY=2^PWM_BITS gives always on.
REQ-027 x_EN SHALL be registered as (state==RUN && pwm_on); x_EN SHALL be 0 in IDLE and DEAD.
REQ-028 x_DIR SHALL be a registered copy of the direction register.
REQ-029 Latency: a CODE change sampled at edge k SHALL update ACTIVE_CODE at edge k, FSM state at edge k+1, and EN/DIR at edge k+2.
REQ-030 BUSY SHALL be registered, equal to (left state==DEAD || right state==DEAD).

Reset
REQ-031 On RST_N low, asynchronously: ACTIVE_CODE=000, both FSMs IDLE, DIR=1, dead counters=0, PWM_CNT=0, LEFT_EN=RIGHT_EN=0, LEFT_DIR=RIGHT_DIR=1, BUSY=0.
REQ-032 Reset mid-DEAD or mid-RUN SHALL abort immediately to the reset values; no dead interval is owed after release.
REQ-033 After RST_N rises, the first action SHALL occur no earlier than the first CLK edge after release.

Structure
REQ-034 The motion code constants (STOP..LEFT2X) and the FSM state encoding SHALL live in a shared package, motion_pkg, also used by the pushbutton-to-code converter.
REQ-035 The per-motor FSM, direction register, dead counter and EN/DIR registers SHALL be one sub-module, motor_channel, instantiated twice.
REQ-036 The top level SHALL hold the code register, the request decode, PWM_CNT and BUSY.

Verification
REQ-037 Reset then CODE=001, DUTY=192: both DIR=1; EN high for 192 of every 256 cycles; first EN no earlier than edge k+2.
REQ-038 CODE 001 -> 010: both EN=0 and BUSY=1 for exactly 16 cycles; DIR then flips to 0 and EN resumes PWM; DIR never toggles while EN=1.
REQ-039 CODE=001, then 000 for 3 cycles, then 010: DIR changes immediately from IDLE with no dead interval, and BUSY stays 0.
REQ-040 CODE=100 from reset: LEFT_DIR=1, RIGHT_DIR=0, both run; then 110: both motors enter DEAD simultaneously, LEFT_DIR ends 0 and RIGHT_DIR ends 1.
REQ-041 CODE=111: treated as STOP, ACTIVE_CODE=000 and both EN=0; DUTY=0 gives EN never high; DUTY=256 gives EN constantly high in RUN.
REQ-042 RST_N pulsed low midway through DEAD: all outputs return to their reset values asynchronously, and CODE=010 after release gives RUN with no dead interval.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared motion-code and motor-FSM definitions, used by the decoder and the
// pushbutton-to-code converter.
package motion_pkg;

  typedef enum logic [2:0] {
    CODE_STOP     = 3'b000,
    CODE_FWD      = 3'b001,
    CODE_REV      = 3'b010,
    CODE_RIGHT1X  = 3'b011,
    CODE_RIGHT2X  = 3'b100,
    CODE_LEFT1X   = 3'b101,
    CODE_LEFT2X   = 3'b110,
    CODE_INVALID  = 3'b111
  } motion_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } motor_state_e;

  typedef enum logic [1:0] {
    REQ_OFF = 2'b00,
    REQ_FWD = 2'b01,
    REQ_REV = 2'b10
  } motor_req_e;

  typedef struct packed {
    motor_req_e left;
    motor_req_e right;
  } drive_req_t;

  localparam int unsigned DEAD_CNT_BITS = 8;

  function automatic drive_req_t decode_code(input motion_code_e code);
    drive_req_t r;
    r = '{left: REQ_OFF, right: REQ_OFF};
    case (code)
      CODE_FWD:     r = '{left: REQ_FWD, right: REQ_FWD};
      CODE_REV:     r = '{left: REQ_REV, right: REQ_REV};
      CODE_RIGHT1X: r = '{left: REQ_FWD, right: REQ_OFF};
      CODE_RIGHT2X: r = '{left: REQ_FWD, right: REQ_REV};
      CODE_LEFT1X:  r = '{left: REQ_OFF, right: REQ_FWD};
      CODE_LEFT2X:  r = '{left: REQ_REV, right: REQ_FWD};
      default:      r = '{left: REQ_OFF, right: REQ_OFF};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor: IDLE/RUN/DEAD FSM with direction register, reversal dead-time
// counter and registered EN/DIR outputs.
module motor_channel
  import motion_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  motor_req_e req,
  input  logic       pwm_on,
  output logic       en,
  output logic       dir,
  output logic       dead
);

  localparam logic [DEAD_CNT_BITS-1:0] DEAD_LOAD = DEAD_CNT_BITS'(DEAD_CYCLES - 1);

  motor_state_e               state, state_next;
  logic                       dir_q, dir_next;
  logic [DEAD_CNT_BITS-1:0]   cnt_q, cnt_next;
  logic                       en_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      dir_q <= 1'b1;
      cnt_q <= '0;
      en    <= 1'b0;
      dir   <= 1'b1;
    end else begin
      state <= state_next;
      dir_q <= dir_next;
      cnt_q <= cnt_next;
      en    <= en_d;
      dir   <= dir_q;
    end
  end

  // NOTE: every combinational output is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    dir_next   = dir_q;
    cnt_next   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (req != REQ_OFF) begin
          state_next = ST_RUN;
          dir_next   = (req == REQ_FWD);
        end
      end
      ST_RUN: begin
        // Direction is frozen in RUN; a reversal must pass through DEAD.
        if (req == REQ_OFF) begin
          state_next = ST_IDLE;
        end else if ((req == REQ_FWD) != dir_q) begin
          state_next = ST_DEAD;
          cnt_next   = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (cnt_q != '0) begin
          cnt_next = cnt_q - 1'b1;
        end else if (req == REQ_OFF) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RUN;
          dir_next   = (req == REQ_FWD);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d = (state == ST_RUN) && pwm_on;
    dead = (state == ST_DEAD);
  end

endmodule

// File: rtl/motion_code_decoder.sv
// Registers the motion code, decodes it into per-motor requests and drives two
// motor channels from a shared free-running PWM counter.
module motion_code_decoder
  import motion_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DUTY        = 192,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] CODE,
  output logic       LEFT_EN,
  output logic       LEFT_DIR,
  output logic       RIGHT_EN,
  output logic       RIGHT_DIR,
  output logic [2:0] ACTIVE_CODE,
  output logic       BUSY
);

  // One extra bit lets DUTY reach 2^PWM_BITS, i.e. always on.
  localparam logic [PWM_BITS:0] DUTY_CMP = (PWM_BITS + 1)'(DUTY);

  motion_code_e          code_q;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  pwm_on;
  drive_req_t            req;
  logic                  left_dead, right_dead;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_q  <= CODE_STOP;
      pwm_cnt <= '0;
      BUSY    <= 1'b0;
    end else begin
      code_q  <= (CODE == CODE_INVALID) ? CODE_STOP : motion_code_e'(CODE);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      BUSY    <= left_dead || right_dead;
    end
  end

  always_comb begin
    pwm_on      = ({1'b0, pwm_cnt} < DUTY_CMP);
    req         = decode_code(code_q);
    ACTIVE_CODE = code_q;
  end

  motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    (req.left),
    .pwm_on (pwm_on),
    .en     (LEFT_EN),
    .dir    (LEFT_DIR),
    .dead   (left_dead)
  );

  motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    (req.right),
    .pwm_on (pwm_on),
    .en     (RIGHT_EN),
    .dir    (RIGHT_DIR),
    .dead   (right_dead)
  );

endmodule
